ucsbece154_mem_arbiter: RTL
===========================

# ucsbece154_mem_arbiter

Arbitrates the single SDRAM-controller port between the instruction-cache refill path and the data-side port. Instruction refills and data reads are BLOCK_WORDS-beat bursts; data writes are single words. Sits between `ucsbece154_icache` / data cache and the SDRAM controller. Grants alternate when both sides are pending, so neither requester can starve the other.

## Interface
- `BLOCK_WORDS`, 4: beats per read burst; power of two ≥ 2.
- `WORD_SIZE`, 32: data width.
- `Clk` in 1: sole clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `IReadRequest` in 1: icache refill request; held until last beat.
- `IReadAddress` in 32: icache refill address.
- `IDataIn` out WORD_SIZE: beat data to icache.
- `IDataReady` out 1: beat valid to icache.
- `DReadRequest` in 1: data-side burst read request; held until last beat.
- `DReadAddress` in 32: data-side read address.
- `DWriteRequest` in 1: data-side word write request; held until `DWriteDone`.
- `DWriteAddress` in 32: write address.
- `DWriteData` in WORD_SIZE: write data.
- `DDataIn` out WORD_SIZE: beat data to data side.
- `DDataReady` out 1: beat valid to data side.
- `DWriteDone` out 1: write-complete pulse.
- `MemReadRequest` out 1: burst read request to controller.
- `MemReadAddress` out 32: block-aligned read address.
- `MemWriteRequest` out 1: word write request to controller.
- `MemWriteAddress` out 32: word-aligned write address.
- `MemWriteData` out WORD_SIZE: write data.
- `MemDataIn` in WORD_SIZE: read beat data.
- `MemDataReady` in 1: read beat valid.
- `MemWriteDone` in 1: controller write-complete pulse.

## Operation
- States: IDLE, I_READ, D_READ, D_WRITE, GAP.
- IDLE selection, one requester per edge:
  - Data-side pending means `DWriteRequest` or `DReadRequest`; `DWriteRequest` wins over `DReadRequest`.
  - Only one side pending: grant it.
  - Both sides pending: grant the side not served last. Register `last_was_i` records this and resets to 0, so data wins first.
- On grant, latch the address and write data.
  - `MemReadAddress` = {addr[31:OFFSET], OFFSET zeros}, OFFSET = 2 + log2(BLOCK_WORDS).
  - `MemWriteAddress` = {addr[31:2], 2'b00}.
- I_READ / D_READ:
  - `Mem*Request` is registered from state.
  - Beat counter width log2(BLOCK_WORDS), cleared on grant, increments on each `MemDataReady`.
  - `MemDataIn` goes combinationally to both `IDataIn` and `DDataIn`.
  - `IDataReady` = `MemDataReady` & (state==I_READ); `DDataReady` = `MemDataReady` & (state==D_READ).
  - After the last beat (counter == BLOCK_WORDS-1 with `MemDataReady`), move to GAP.
- D_WRITE: on `MemWriteDone`, pulse `DWriteDone` for one cycle (registered), then move to GAP.
- GAP: one cycle, no grant. Absorbs the requester's registered request drop. Then IDLE.
- `MemDataReady` / `MemWriteDone` outside the matching state: ignored, not forwarded, no state change.
- Requester drops its request mid-burst: the burst still runs to BLOCK_WORDS beats; beats are still forwarded.
- Reset values: all `Mem*Request`, `IDataReady`, `DDataReady`, `DWriteDone` = 0; addresses and data = 0; state IDLE; counter 0.
- Reset mid-burst aborts immediately; the controller is reset alongside.

## Timing
- Request visible in IDLE at edge N → `Mem*Request` high in cycle N+1.
- Beat data: zero-cycle forward.
- Last beat in cycle M → `MemReadRequest` low in M+1 (GAP), IDLE in M+2, next grant visible M+3.
- `MemWriteDone` in cycle W → `DWriteDone` high in W+1 only; `MemWriteRequest` low in W+1.
- Back-to-back alternating bursts: 2 idle cycles between bursts.

## Structure
- Shared package `ucsbece154_mem_pkg` holds:
  - state enum encoding,
  - OFFSET / WORD_OFFSET localparam functions,
  - the 2-way round-robin pick function.
- Single module; no sub-module. The beat counter and FSM are inline.

## Test plan
- Reset, then idle: all outputs 0 for 5 cycles; stray `MemDataReady` → no `IDataReady` / `DDataReady`.
- Icache refill at 0x0000_0134, BLOCK_WORDS=4, beats 0xA0..0xA3 → `MemReadAddress`=0x0000_0130; `IDataReady` ×4 with matching data; `MemReadRequest` low the cycle after the 4th beat.
- I and D reads raised the same cycle from reset → D served first; I granted at M+3; a third D request during the I burst waits until after it.
- Data write 0x200/0xDEADBEEF while the icache requests → write first, `DWriteDone` one-cycle pulse, then I burst.
- Reset asserted after beat 2 → next cycle all requests 0 and state IDLE; a fresh request is granted normally.
- Requester drops its request after beat 1 → arbiter still consumes 4 beats before GAP.

Source files
------------

// File: rtl/ucsbece154_mem_pkg.sv
// Shared types and helpers for the SDRAM port arbiter: FSM encoding,
// address offset widths and the two-way round-robin pick.
package ucsbece154_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_READ  = 3'd1,
    D_READ  = 3'd2,
    D_WRITE = 3'd3,
    GAP     = 3'd4
  } arb_state_t;

  // Byte-offset bits inside a read block.
  function automatic int offset_bits(input int block_words);
    return 2 + $clog2(block_words);
  endfunction

  // Byte-offset bits inside a word.
  function automatic int word_offset_bits();
    return 2;
  endfunction

  // Returns 1 when the icache side should be granted. On contention the side
  // not served last wins; before anything has been served the data side wins.
  function automatic logic pick_i(input logic i_pend, input logic d_pend,
                                  input logic primed, input logic last_was_i);
    if (i_pend && d_pend) return primed && !last_was_i;
    return i_pend;
  endfunction

endpackage

// File: rtl/ucsbece154_mem_arbiter.sv
// Shares the single SDRAM-controller port between icache refills and the
// data side (burst reads, single-word writes), alternating under contention.
module ucsbece154_mem_arbiter
  import ucsbece154_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 IReadRequest,
  input  logic [31:0]          IReadAddress,
  output logic [WORD_SIZE-1:0] IDataIn,
  output logic                 IDataReady,
  input  logic                 DReadRequest,
  input  logic [31:0]          DReadAddress,
  input  logic                 DWriteRequest,
  input  logic [31:0]          DWriteAddress,
  input  logic [WORD_SIZE-1:0] DWriteData,
  output logic [WORD_SIZE-1:0] DDataIn,
  output logic                 DDataReady,
  output logic                 DWriteDone,
  output logic                 MemReadRequest,
  output logic [31:0]          MemReadAddress,
  output logic                 MemWriteRequest,
  output logic [31:0]          MemWriteAddress,
  output logic [WORD_SIZE-1:0] MemWriteData,
  input  logic [WORD_SIZE-1:0] MemDataIn,
  input  logic                 MemDataReady,
  input  logic                 MemWriteDone
);

  localparam int          OFFSET      = offset_bits(BLOCK_WORDS);
  localparam int          WORD_OFFSET = word_offset_bits();
  localparam int          CW          = $clog2(BLOCK_WORDS);
  localparam logic [31:0] RD_MASK     = ~((32'd1 << OFFSET) - 32'd1);
  localparam logic [31:0] WR_MASK     = ~((32'd1 << WORD_OFFSET) - 32'd1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BLOCK_WORDS - 1);

  arb_state_t    state, state_n;
  logic [CW-1:0] beat_cnt;
  logic          last_was_i, primed;
  logic          d_pend, grant_i, grant_dr, grant_dw, last_beat, write_done;
  logic          reading;

  assign d_pend  = DWriteRequest | DReadRequest;
  assign reading = (state == I_READ) || (state == D_READ);

  always_comb begin
    state_n    = state;
    grant_i    = 1'b0;
    grant_dr   = 1'b0;
    grant_dw   = 1'b0;
    last_beat  = 1'b0;
    write_done = 1'b0;
    case (state)
      IDLE: begin
        if (IReadRequest || d_pend) begin
          if (pick_i(IReadRequest, d_pend, primed, last_was_i)) begin
            grant_i = 1'b1;
            state_n = I_READ;
          end else if (DWriteRequest) begin
            grant_dw = 1'b1;
            state_n  = D_WRITE;
          end else begin
            grant_dr = 1'b1;
            state_n  = D_READ;
          end
        end
      end
      I_READ, D_READ: begin
        if (MemDataReady && beat_cnt == LAST_BEAT) begin
          last_beat = 1'b1;
          state_n   = GAP;
        end
      end
      D_WRITE: begin
        if (MemWriteDone) begin
          write_done = 1'b1;
          state_n    = GAP;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      last_was_i      <= 1'b0;
      primed          <= 1'b0;
      MemReadRequest  <= 1'b0;
      MemReadAddress  <= '0;
      MemWriteRequest <= 1'b0;
      MemWriteAddress <= '0;
      MemWriteData    <= '0;
      DWriteDone      <= 1'b0;
    end else begin
      state      <= state_n;
      DWriteDone <= write_done;

      if (grant_i || grant_dr) begin
        MemReadRequest <= 1'b1;
        MemReadAddress <= (grant_i ? IReadAddress : DReadAddress) & RD_MASK;
      end else if (last_beat) begin
        MemReadRequest <= 1'b0;
      end

      if (grant_dw) begin
        MemWriteRequest <= 1'b1;
        MemWriteAddress <= DWriteAddress & WR_MASK;
        MemWriteData    <= DWriteData;
      end else if (write_done) begin
        MemWriteRequest <= 1'b0;
      end

      if (grant_i || grant_dr)        beat_cnt <= '0;
      else if (reading && MemDataReady) beat_cnt <= beat_cnt + CW'(1);

      if (grant_i || grant_dr || grant_dw) begin
        last_was_i <= grant_i;
        primed     <= 1'b1;
      end
    end
  end

  // Beat data is forwarded to both sides; only the owner sees a valid strobe.
  assign IDataIn    = MemDataIn;
  assign DDataIn    = MemDataIn;
  assign IDataReady = MemDataReady && (state == I_READ);
  assign DDataReady = MemDataReady && (state == D_READ);

endmodule
